fft_ctrl_in: RTL and testbench
==============================

Name: fft_ctrl_in

Overview:
Streaming source feeding the FFT core's sink port. On a start pulse it reads one full frame of N = 2^ADDR_WIDTH complex samples from the acquisition RAM, addresses 0..N-1 in order. It presents them to the FFT core as an Avalon-ST packet with sop/eop/valid, honouring the core's ready backpressure. It sits directly upstream of the FFT core, whose output feeds the FFT-output-to-RAM controller.

Parameters:
ADDR_WIDTH, 10, RAM address width; frame length N = 2^ADDR_WIDTH
DATA_WIDTH, 16, width of each real/imag sample component

Ports:
CLK  in  1  system clock; all logic on rising edge
RST  in  1  synchronous, active-high reset
start  in  1  one-cycle request to stream a frame; honoured only in IDLE
inverse  in  1  FFT direction; sampled with an accepted start
busy  out  1  frame in progress
done  out  1  one-cycle pulse after the last sample transfers
ram_addr  out  ADDR_WIDTH  RAM read address
ram_rden  out  1  RAM read enable
ram_q  in  2*DATA_WIDTH  RAM read data; 1-cycle read latency; [2*DATA_WIDTH-1:DATA_WIDTH]=real, [DATA_WIDTH-1:0]=imag
sink_ready  in  1  FFT core ready (ready latency 0)
sink_valid  out  1  sample valid
sink_sop  out  1  start of packet; asserted with sample 0
sink_eop  out  1  end of packet; asserted with sample N-1
sink_real  out  DATA_WIDTH  sample real part
sink_imag  out  DATA_WIDTH  sample imaginary part
sink_inverse  out  1  latched inverse flag, held for the whole frame

Behaviour:
- Reset: synchronous only; all outputs are 0 and the state is IDLE.
- Reset mid-frame: outputs go to 0 on the same edge and the state returns to IDLE. No eop and no done are emitted. Read data already in flight is discarded.
- Transfer rule: a sample transfers on any cycle with sink_valid && sink_ready.
  - While sink_valid=1 and sink_ready=0, sink_valid, sink_sop, sink_eop, sink_real and sink_imag hold stable.
- Read timing: a read issued in cycle c (ram_rden=1, ram_addr=k) returns word k on ram_q in cycle c+1, where it is captured.
- Buffering: output register plus a one-entry skid register.
  - A read is issued only if (occupied entries + reads in flight) < 2.
  - No sample is lost or duplicated under any ready pattern.
- States:
  - IDLE: busy=0. A start moves to STREAM, latches inverse into sink_inverse and clears the address and transfer counters.
  - STREAM: busy=1. Issues reads k=0..N-1 per the buffering rule, then drives ram_rden=0. ram_addr holds at N-1 and never wraps. A transfer counter counts sample transfers. The transfer of sample N-1 moves to DONE.
  - DONE: busy=1 and done=1 for exactly one cycle, sink_valid=0, then IDLE.
- Latency: with start accepted at edge t (start high in cycle t) and sink_ready held at 1:
  - ram_rden=1 with ram_addr=0 in cycle t+1.
  - Sample k is valid in cycle t+3+k.
  - eop is in cycle t+2+N and done in cycle t+3+N.
  - Full throughput is one sample per cycle.
- sop only with transfer index 0; eop only with index N-1. Both are 0 whenever sink_valid=0.
- A start in STREAM or DONE is ignored with no side effect. A start in the cycle after done (IDLE) is accepted.
- A change on inverse during a frame has no effect until the next accepted start.
- Data is a plain bit-slice of ram_q with no arithmetic or sign change.

Test Plan:
- Sanity: ADDR_WIDTH=4 (N=16), RAM word k = {k, ~k}, start with sink_ready=1 -> sink_real 0..15 consecutive from cycle t+3; sop with 0, eop with 15; done one cycle later; busy low after done.
- Backpressure: sink_ready toggles 1,0,0,1 repeating -> exactly 16 transfers in order 0..15 with no gaps or duplicates; outputs stable whenever ready=0; ram_addr never exceeds 15.
- Ready low from start: sink_ready=0 for 20 cycles after start -> at most 2 reads issued (ram_addr 0,1); sample 0 with sop held valid; stream completes normally once ready=1.
- Reset mid-frame: RST for one cycle after 7 transfers -> all outputs 0 next cycle, no eop/done; a new start streams samples 0..15 from the beginning.
- Start while busy and inverse latch: inverse=1 at start, then start pulses plus inverse=0 mid-frame -> sink_inverse=1 for the whole frame, a single packet of 16, one done pulse.
- Back-to-back: start in the cycle after done -> second packet identical to the first, sop on its first sample.

Source files
------------

// File: rtl/fft_ctrl_in.sv
// Streams one frame of N = 2^ADDR_WIDTH complex samples from the acquisition RAM
// into the FFT core sink as an Avalon-ST packet (sop/eop/valid, ready latency 0).
// The datapath is an output register plus a one-entry skid register. RAM reads are
// throttled so that held samples plus reads in flight never exceed those two entries.
module fft_ctrl_in #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    start,
  input  logic                    inverse,
  output logic                    busy,
  output logic                    done,
  output logic [ADDR_WIDTH-1:0]   ram_addr,
  output logic                    ram_rden,
  input  logic [2*DATA_WIDTH-1:0] ram_q,
  input  logic                    sink_ready,
  output logic                    sink_valid,
  output logic                    sink_sop,
  output logic                    sink_eop,
  output logic [DATA_WIDTH-1:0]   sink_real,
  output logic [DATA_WIDTH-1:0]   sink_imag,
  output logic                    sink_inverse
);

  typedef enum logic [1:0] {StIdle, StStream, StDone} state_e;

  localparam logic [ADDR_WIDTH-1:0] LastIdx = '1;

  state_e                  state_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [ADDR_WIDTH-1:0]   xfer_cnt_q;
  logic                    rd_all_q;    // all N reads have been issued
  logic                    rd_pend_q;   // a read issued last cycle returns on ram_q now
  logic                    inverse_q;

  logic                    out_valid_q, out_valid_d;
  logic [2*DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                    skid_valid_q, skid_valid_d;
  logic [2*DATA_WIDTH-1:0] skid_data_q, skid_data_d;

  logic                    xfer;
  logic [1:0]              occ_after;
  logic                    rd_issue;

  // Transfer handshake and read throttle. Occupancy is counted after this cycle's
  // transfer so a continuously ready sink sustains one sample per cycle.
  always_comb begin
    xfer      = out_valid_q & sink_ready;
    occ_after = 2'(skid_valid_q) + 2'(out_valid_q & ~xfer) + 2'(rd_pend_q);
    rd_issue  = (state_q == StStream) && !rd_all_q && (occ_after < 2'd2);
  end

  // Control FSM: frame sequencing, read address and transfer counting.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      xfer_cnt_q <= '0;
      rd_all_q   <= 1'b0;
      rd_pend_q  <= 1'b0;
      inverse_q  <= 1'b0;
    end else begin
      rd_pend_q <= rd_issue;
      case (state_q)
        StIdle: begin
          if (start) begin
            state_q    <= StStream;
            inverse_q  <= inverse;
            addr_q     <= '0;
            xfer_cnt_q <= '0;
            rd_all_q   <= 1'b0;
          end
        end
        StStream: begin
          if (rd_issue) begin
            // Address parks at N-1 after the final read instead of wrapping.
            if (addr_q == LastIdx) begin
              rd_all_q <= 1'b1;
            end else begin
              addr_q <= addr_q + 1'b1;
            end
          end
          if (xfer) begin
            xfer_cnt_q <= xfer_cnt_q + 1'b1;
            if (xfer_cnt_q == LastIdx) begin
              state_q <= StDone;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Output/skid next state: refill the output from the skid first, then from RAM;
  // returning data lands in the skid when the output is held by backpressure.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (!out_valid_q || xfer) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        skid_valid_d = rd_pend_q;
        if (rd_pend_q) begin
          skid_data_d = ram_q;
        end
      end else begin
        out_valid_d = rd_pend_q;
        if (rd_pend_q) begin
          out_data_d = ram_q;
        end
      end
    end else if (rd_pend_q) begin
      skid_valid_d = 1'b1;
      skid_data_d  = ram_q;
    end
  end

  // Output and skid registers; reset drops any sample held or in flight.
  always_ff @(posedge CLK) begin
    if (RST) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
    end
  end

  // Output decode; every term derives from registered state except the read
  // enable, which must see this cycle's ready to keep full throughput.
  always_comb begin
    busy         = (state_q != StIdle);
    done         = (state_q == StDone);
    ram_addr     = addr_q;
    ram_rden     = rd_issue;
    sink_valid   = out_valid_q;
    sink_sop     = out_valid_q && (xfer_cnt_q == '0);
    sink_eop     = out_valid_q && (xfer_cnt_q == LastIdx);
    sink_real    = out_data_q[2*DATA_WIDTH-1:DATA_WIDTH];
    sink_imag    = out_data_q[DATA_WIDTH-1:0];
    sink_inverse = inverse_q;
  end

endmodule

// File: tb/tb_fft_ctrl_in.sv
// Bench for fft_ctrl_in with N = 16. A RAM model returns word k = {k, ~k} one cycle
// after a read. A frame-level model checks every cycle; directed tests add literal
// latency and count expectations.
module tb_fft_ctrl_in;

  localparam int AW = 4;
  localparam int DW = 16;
  localparam int N  = 16;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          start = 1'b0;
  logic          inverse = 1'b0;
  logic          busy, done;
  logic [AW-1:0] ram_addr;
  logic          ram_rden;
  logic [2*DW-1:0] ram_q = '0;
  logic          sink_ready = 1'b1;
  logic          sink_valid, sink_sop, sink_eop;
  logic [DW-1:0] sink_real, sink_imag;
  logic          sink_inverse;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  fft_ctrl_in #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .CLK(CLK), .RST(RST), .start(start), .inverse(inverse),
    .busy(busy), .done(done), .ram_addr(ram_addr), .ram_rden(ram_rden),
    .ram_q(ram_q), .sink_ready(sink_ready), .sink_valid(sink_valid),
    .sink_sop(sink_sop), .sink_eop(sink_eop), .sink_real(sink_real),
    .sink_imag(sink_imag), .sink_inverse(sink_inverse)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // RAM with one-cycle read latency; garbage when not read.
  always @(posedge CLK) begin
    if (ram_rden) ram_q <= {16'(ram_addr), ~16'(ram_addr)};
    else          ram_q <= 32'hDEAD_BEEF;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  int   m_phase = 0;           // 0 idle, 1 streaming, 2 done cycle
  int   m_idx = 0, m_rd = 0, m_xf = 0, m_pkts = 0, m_dones = 0;
  bit   m_inv = 1'b0;
  bit   m_rst_prev = 1'b1;
  logic prev_valid = 1'b0, prev_ready = 1'b0;
  logic [34:0] prev_out = '0, cur;
  logic [15:0] exp_real;
  int   f_t = -1, f_rden = -1, f_valid = -1, f_eop = -1, f_done = -1;

  always @(negedge CLK) begin
    cur = {sink_valid, sink_sop, sink_eop, sink_real, sink_imag};
    exp_real = m_idx[15:0];
    if (m_rst_prev) begin
      chk("reset_outputs", 64'({busy, done, ram_rden, ram_addr, cur, sink_inverse}), 64'(0));
    end else begin
      if (prev_valid && !prev_ready) chk("hold_stable", 64'(cur), 64'(prev_out));
      if (!sink_valid) chk("sop_eop_without_valid", 64'({sink_sop, sink_eop}), 64'(0));
      case (m_phase)
        0: chk("idle_flags", 64'({busy, done, sink_valid, ram_rden}), 64'(0));
        1: begin
          chk("stream_flags", 64'({busy, done, sink_inverse}), 64'({1'b1, 1'b0, m_inv}));
          if (ram_rden) begin
            chk("rd_addr", 64'(ram_addr), 64'(m_rd[3:0]));
            chk("rd_count_in_range", 64'(m_rd < N), 64'(1));
            if (f_rden < 0) f_rden = cyc;
            m_rd++;
          end
          if (sink_valid) begin
            chk("sample", 64'({sink_real, sink_imag, sink_sop, sink_eop}),
                64'({exp_real, ~exp_real, m_idx == 0, m_idx == N - 1}));
            if (f_valid < 0) f_valid = cyc;
            if (sink_eop && f_eop < 0) f_eop = cyc;
          end
        end
        default: begin
          chk("done_flags", 64'({busy, done, sink_valid, ram_rden}), 64'(4'b1100));
          f_done = cyc;
        end
      endcase
    end
    // phase update from this cycle's inputs
    if (RST) begin
      m_phase = 0;
    end else begin
      case (m_phase)
        0: if (start) begin
          m_phase = 1; m_inv = inverse; m_idx = 0; m_rd = 0; m_xf = 0;
          f_t = cyc; f_rden = -1; f_valid = -1; f_eop = -1; f_done = -1;
        end
        1: begin
          if (sink_valid && sink_ready) begin
            m_xf++;
            if (m_idx == N - 1) begin
              m_phase = 2;
              m_pkts++;
            end
            m_idx++;
          end
          chk("outstanding_le_2", 64'((m_rd - m_xf) <= 2), 64'(1));
        end
        default: begin
          m_phase = 0;
          m_dones++;
        end
      endcase
    end
    m_rst_prev = RST;
    prev_valid = sink_valid;
    prev_ready = sink_ready;
    prev_out   = cur;
  end

  // ---------------- ready driver ----------------
  int rdy_mode = 0;
  int rdy_ph = 0;
  initial begin
    forever begin
      @(posedge CLK);
      #1;
      rdy_ph++;
      case (rdy_mode)
        0: sink_ready = 1'b1;
        1: sink_ready = (rdy_ph % 4 == 0) || (rdy_ph % 4 == 3);
        default: sink_ready = 1'b0;
      endcase
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_start(input bit inv);
    start = 1'b1;
    inverse = inv;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int maxc);
    int d0;
    bit seen;
    d0 = m_dones;
    seen = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      tick();
      if (m_dones != d0) begin
        seen = 1'b1;
        break;
      end
    end
    chk("done_within_budget", 64'(seen), 64'(1));
  endtask

  int p0, d0;
  bit seen_done;

  initial begin
    repeat (3) tick();
    RST = 1'b0;
    tick();

    // Sanity: full-rate frame and latency
    rdy_mode = 0;
    do_start(1'b0);
    wait_done(100);
    chk("busy_low_after_done", 64'(busy), 64'(0));
    chk("lat_first_rden", 64'(f_rden - f_t), 64'(1));
    chk("lat_first_valid", 64'(f_valid - f_t), 64'(3));
    chk("lat_eop", 64'(f_eop - f_t), 64'(N + 2));
    chk("lat_done", 64'(f_done - f_t), 64'(N + 3));
    chk("sanity_pkts", 64'(m_pkts), 64'(1));
    chk("sanity_dones", 64'(m_dones), 64'(1));
    repeat (2) tick();

    // Backpressure 1,0,0,1
    rdy_mode = 1;
    do_start(1'b0);
    wait_done(200);
    chk("bp_transfers", 64'(m_xf), 64'(16));
    chk("bp_pkts", 64'(m_pkts), 64'(2));
    rdy_mode = 0;
    repeat (2) tick();

    // Ready low from start
    rdy_mode = 2;
    repeat (2) tick();
    do_start(1'b0);
    repeat (20) tick();
    chk("stall_reads", 64'(m_rd), 64'(2));
    chk("stall_head", 64'({sink_valid, sink_sop, sink_real}), 64'({1'b1, 1'b1, 16'h0000}));
    rdy_mode = 0;
    wait_done(100);
    chk("stall_pkts", 64'(m_pkts), 64'(3));
    repeat (2) tick();

    // Reset mid-frame after 7 transfers
    p0 = m_pkts;
    d0 = m_dones;
    rdy_mode = 1;
    do_start(1'b0);
    for (int i = 0; i < 100 && m_xf < 7; i++) tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    tick();
    chk("rst_no_eop", 64'(m_pkts), 64'(p0));
    chk("rst_no_done", 64'(m_dones), 64'(d0));
    rdy_mode = 0;
    do_start(1'b0);
    wait_done(100);
    chk("rst_restart_pkts", 64'(m_pkts), 64'(p0 + 1));
    repeat (2) tick();

    // Start while busy, inverse latch
    p0 = m_pkts;
    d0 = m_dones;
    rdy_mode = 1;
    do_start(1'b1);
    seen_done = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      start = 1'b0;
      if (m_dones != d0) begin
        seen_done = 1'b1;
        break;
      end
      inverse = 1'b0;
      if (i % 3 == 0 && busy) start = 1'b1;
    end
    start = 1'b0;
    chk("busy_start_done_seen", 64'(seen_done), 64'(1));
    chk("busy_start_pkts", 64'(m_pkts), 64'(p0 + 1));
    chk("busy_start_dones", 64'(m_dones), 64'(d0 + 1));
    repeat (3) tick();
    chk("busy_start_idle", 64'({busy, sink_valid}), 64'(0));
    rdy_mode = 0;
    tick();

    // Back-to-back
    p0 = m_pkts;
    do_start(1'b0);
    wait_done(100);
    do_start(1'b1);
    chk("b2b_accepted", 64'(busy), 64'(1));
    wait_done(100);
    chk("b2b_pkts", 64'(m_pkts), 64'(p0 + 2));
    chk("b2b_lat_valid", 64'(f_valid - f_t), 64'(3));
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
